// File: rtl/rx_sample_if.sv
// Bundle of the receiver's line inputs and sample/byte/EOP indications.
// master drives the synchronized line; slave is the sample controller.
interface rx_sample_if;
    logic       rx_enable;
    logic       d_edge;
    logic       d_plus_sync;
    logic       d_minus_sync;
    logic       shift_enable;
    logic       byte_received;
    logic       eop_detected;
    logic       rx_active;
    logic [2:0] bit_cnt;

    modport master (
        output rx_enable, d_edge, d_plus_sync, d_minus_sync,
        input  shift_enable, byte_received, eop_detected, rx_active, bit_cnt
    );

    modport slave (
        input  rx_enable, d_edge, d_plus_sync, d_minus_sync,
        output shift_enable, byte_received, eop_detected, rx_active, bit_cnt
    );
endinterface

// File: rtl/rx_sample_ctrl.sv
// USB receive bit-sampling controller: recovers the mid-bit sample point from
// D+ edges, counts bits into bytes and recognises SE0-SE0 end-of-packet.
module rx_sample_ctrl #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    rx_sample_if.slave  rx
);
    localparam int              CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        EOP     = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] clk_cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic             se0_seen_reg;
    logic             byte_received_reg;
    logic             eop_detected_reg;
    logic             rx_active_reg;

    logic sample;
    logic se0;

    // Sample point is decoded from registers only, so it never glitches with d_edge.
    assign sample = (state_reg == RECEIVE) && (clk_cnt_reg == SAMPLE_AT);
    assign se0    = !rx.d_plus_sync && !rx.d_minus_sync;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg         <= IDLE;
            clk_cnt_reg       <= '0;
            bit_cnt_reg       <= '0;
            se0_seen_reg      <= 1'b0;
            byte_received_reg <= 1'b0;
            eop_detected_reg  <= 1'b0;
            rx_active_reg     <= 1'b0;
        end else begin
            byte_received_reg <= 1'b0;
            eop_detected_reg  <= 1'b0;
            if (!rx.rx_enable) begin
                state_reg     <= IDLE;
                clk_cnt_reg   <= '0;
                bit_cnt_reg   <= '0;
                se0_seen_reg  <= 1'b0;
                rx_active_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (rx.d_edge) begin
                            state_reg     <= RECEIVE;
                            rx_active_reg <= 1'b1;
                            clk_cnt_reg   <= '0;
                            bit_cnt_reg   <= '0;
                            se0_seen_reg  <= 1'b0;
                        end
                    end
                    RECEIVE: begin
                        if (rx.d_edge || (clk_cnt_reg == CNT_MAX))
                            clk_cnt_reg <= '0;
                        else
                            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                        if (sample) begin
                            if (se0 && se0_seen_reg) begin
                                // Second SE0 in a row: drop the partial byte.
                                state_reg        <= EOP;
                                eop_detected_reg <= 1'b1;
                                bit_cnt_reg      <= '0;
                                se0_seen_reg     <= 1'b0;
                                clk_cnt_reg      <= '0;
                            end else begin
                                se0_seen_reg      <= se0;
                                bit_cnt_reg       <= bit_cnt_reg + 3'd1;
                                byte_received_reg <= (bit_cnt_reg == 3'd7);
                            end
                        end
                    end
                    EOP: begin
                        if (rx.d_plus_sync && !rx.d_minus_sync) begin
                            state_reg     <= IDLE;
                            rx_active_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg     <= IDLE;
                        rx_active_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx.shift_enable  = sample;
    assign rx.byte_received = byte_received_reg;
    assign rx.eop_detected  = eop_detected_reg;
    assign rx.rx_active     = rx_active_reg;
    assign rx.bit_cnt       = bit_cnt_reg;
endmodule

// File: tb/tb_rx_sample_ctrl.sv
// Randomized packet traffic for rx_sample_ctrl, checked by a scoreboard fed
// from a bit-timing reference model (sample phase = cycles since last edge).
module tb_rx_sample_ctrl;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    rx_sample_if bus ();

    rx_sample_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .rx    (bus)
    );

    typedef struct { int cyc; logic act; logic [2:0] bc; } lvl_t;
    typedef struct { int cyc; logic [2:0] p; } pls_t;
    lvl_t lq[$];
    pls_t pq[$];

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int   cyc = 0;
    bit   m_rx = 0, m_eop = 0;
    int   anchor = 0, bits = 0, se0run = 0;
    bit   pend_br = 0, pend_eop = 0;
    logic prev_dp = 1'b1;

    task automatic model_clear();
        m_rx = 0; m_eop = 0; bits = 0; se0run = 0; pend_br = 0; pend_eop = 0;
    endtask

    task automatic step(input bit en, input bit dp, input bit dm, input bit rl);
        bit   fell;
        bit   edge_now;
        bit   se;
        lvl_t l;
        pls_t p;
        @(posedge clk);
        #1;
        fell     = n_rst && !rl;
        edge_now = (dp != prev_dp);
        prev_dp  = dp;
        bus.rx_enable    = en;
        bus.d_edge       = edge_now;
        bus.d_plus_sync  = dp;
        bus.d_minus_sync = dm;
        n_rst            = rl;
        if (!rl) model_clear();
        se = m_rx && (((cyc - anchor) % CPB) == (CPB / 2 - 1));
        l.cyc = cyc; l.act = m_rx || m_eop; l.bc = 3'(bits);
        lq.push_back(l);
        if (se || pend_br || pend_eop) begin
            p.cyc = cyc; p.p = {se, pend_br, pend_eop};
            pq.push_back(p);
        end
        if (rl) begin
            pend_br = 0; pend_eop = 0;
            if (!en) begin
                model_clear();
            end else if (m_rx) begin
                if (se) begin
                    if (!dp && !dm && se0run >= 1) begin
                        pend_eop = 1; m_rx = 0; m_eop = 1; bits = 0; se0run = 0;
                    end else begin
                        se0run = (!dp && !dm) ? se0run + 1 : 0;
                        if (bits == 7) pend_br = 1;
                        bits = (bits + 1) % 8;
                    end
                end
                if (edge_now) anchor = cyc + 1;
            end else if (m_eop) begin
                if (dp && !dm) m_eop = 0;
            end else if (edge_now) begin
                m_rx = 1; anchor = cyc + 1; bits = 0; se0run = 0;
            end
        end
        if (fell) begin
            #1;
            compared++;
            if ({bus.shift_enable, bus.byte_received, bus.eop_detected,
                 bus.rx_active, bus.bit_cnt} != 7'd0) begin
                mismatched++;
                $display("FAIL async_reset cyc=%0d: got se=%b br=%b eop=%b act=%b bc=%0d, required all 0",
                         cyc, bus.shift_enable, bus.byte_received, bus.eop_detected,
                         bus.rx_active, bus.bit_cnt);
            end
        end
        cyc++;
    endtask

    task automatic hold(input bit dp, input bit dm, input int n);
        for (int i = 0; i < n; i++) step(1'b1, dp, dm, 1'b1);
    endtask

    // One packet: SYNC-like K start, random J/K bits, then SE0 SE0 J.
    // kind 1 drops rx_enable mid-packet, kind 2 pulses reset, kind 3 adds a lone SE0.
    task automatic packet(input int kind);
        int nb, cut, len;
        bit dp;
        nb  = $urandom_range(1, 30);
        cut = $urandom_range(0, nb - 1);
        dp  = 1'b1;
        hold(1'b1, 1'b0, $urandom_range(3, 12));
        for (int i = 0; i < nb; i++) begin
            if (i == 0) dp = 1'b0;
            else if ($urandom_range(0, 2) == 0) dp = ~dp;
            len = ($urandom_range(0, 5) == 0) ? CPB / 2 : CPB + $urandom_range(0, 2) - 1;
            for (int c = 0; c < len; c++) begin
                if (kind == 1 && i == cut && c < 2)
                    step(1'b0, dp, ~dp, 1'b1);
                else if (kind == 2 && i == cut && c < 3)
                    step(1'b1, dp, ~dp, 1'b0);
                else
                    step(1'b1, dp, ~dp, 1'b1);
            end
        end
        if (kind == 3) begin
            hold(1'b0, 1'b0, CPB);
            hold(1'b0, 1'b1, CPB);
        end
        hold(1'b0, 1'b0, 2 * CPB + $urandom_range(0, 2) - 1);
        hold(1'b1, 1'b0, $urandom_range(1, 6));
    endtask

    // Monitor: one level entry per cycle, pulse entries only when expected.
    initial begin
        lvl_t l;
        pls_t p;
        logic [2:0] got;
        forever begin
            @(negedge clk);
            if (lq.size() > 0) begin
                l = lq.pop_front();
                compared++;
                if (bus.rx_active !== l.act || bus.bit_cnt !== l.bc) begin
                    mismatched++;
                    $display("FAIL level cyc=%0d: got rx_active=%b bit_cnt=%0d, required rx_active=%b bit_cnt=%0d",
                             l.cyc, bus.rx_active, bus.bit_cnt, l.act, l.bc);
                end
                got = {bus.shift_enable, bus.byte_received, bus.eop_detected};
                while (pq.size() > 0 && pq[0].cyc < l.cyc) begin
                    p = pq.pop_front();
                    compared++;
                    mismatched++;
                    $display("FAIL pulse_missing cyc=%0d: got none, required se/br/eop=%b", p.cyc, p.p);
                end
                if (pq.size() > 0 && pq[0].cyc == l.cyc) begin
                    p = pq.pop_front();
                    compared++;
                    if (got !== p.p) begin
                        mismatched++;
                        $display("FAIL pulses cyc=%0d: got se/br/eop=%b, required %b", l.cyc, got, p.p);
                    end
                end else if (got !== 3'b000) begin
                    compared++;
                    mismatched++;
                    $display("FAIL pulse_unexpected cyc=%0d: got se/br/eop=%b, required 000", l.cyc, got);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_enable    = 1'b0;
        bus.d_edge       = 1'b0;
        bus.d_plus_sync  = 1'b1;
        bus.d_minus_sync = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 4);
        for (int k = 0; k < 40; k++) begin
            packet(k % 4);
            $display("packet %0d kind=%0d done at cycle %0d", k, k % 4, cyc);
        end
        hold(1'b1, 1'b0, 20);
        repeat (3) @(negedge clk);
        while (pq.size() > 0) begin
            pls_t p;
            p = pq.pop_front();
            compared++;
            mismatched++;
            $display("FAIL pulse_missing cyc=%0d: got none, required se/br/eop=%b", p.cyc, p.p);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
